// File: rtl/framed_deserializer.sv
// -----------------------------------------------------------------------------
// framed_deserializer
//
// Receive-side serial-to-parallel converter. Hunts for a start bit (0) on one
// serial lane, captures DATA_WIDTH payload bits, checks the stop bit (1) and
// pushes good words into a small output FIFO drained by a valid/ready consumer.
// Frame = 1 start + DATA_WIDTH payload + 1 stop, one bit per clk.
//
// Parameters
//   DATA_WIDTH  payload bits per frame (>= 2)
//   MSB_FIRST   0: first payload bit lands in bit 0; 1: in bit DATA_WIDTH-1
//   FIFO_DEPTH  output FIFO entries (power of 2, >= 2)
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous, active-low reset
//   en         in   receiver enable; dropping it abandons the current frame
//   in_bit     in   serial input, idle high
//   out_data   out  FIFO head word (0 while the FIFO is empty)
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer takes the head when out_valid & out_ready
//   level      out  FIFO occupancy, 0..FIFO_DEPTH
//   frame_err  out  1-cycle pulse after a STOP cycle that saw a 0 stop bit
//   overflow   out  1-cycle pulse after a good word was dropped on a full FIFO
// -----------------------------------------------------------------------------
module framed_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_bit,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  // Insert one serial bit into the partially assembled word. LSB-first shifts
  // right so the first bit ends in bit 0 after DATA_WIDTH shifts; MSB-first
  // shifts left so the first bit ends in the top bit.
  function automatic logic [DATA_WIDTH-1:0] shift_in(
    input logic [DATA_WIDTH-1:0] cur,
    input logic                  b
  );
    if (MSB_FIRST != 0)
      shift_in = {cur[DATA_WIDTH-2:0], b};
    else
      shift_in = {b, cur[DATA_WIDTH-1:1]};
  endfunction

  logic [1:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] word_p0;

  logic                  vld_p0;
  logic                  bad_stop_p0;
  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic                  push_drop;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         count;

  // ---- stage 0: frame capture (start hunt, payload shift, stop check) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      word_p0 <= '0;
    end else if (!en) begin
      // Abandon any partial frame; nothing is reported for it.
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!in_bit) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          word_p0 <= shift_in(word_p0, in_bit);
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT)
            state <= S_STOP;
        end
        S_STOP: begin
          // The stop-bit cycle never doubles as a start-bit cycle.
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign vld_p0      = en && (state == S_STOP) &&  in_bit;
  assign bad_stop_p0 = en && (state == S_STOP) && !in_bit;

  // ---- stage 1: output FIFO and registered status pulses ----
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == FULL_LVL);
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok   = vld_p0 && (!full || pop);
  assign push_drop = vld_p0 && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= word_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= bad_stop_p0;
      overflow  <= push_drop;
    end
  end

  // The storage array is not reset, so the head is masked while empty.
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign level    = count;

endmodule

// File: tb/tb_framed_deserializer.sv
module tb_framed_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_bit;
  logic       out_ready;
  logic       out_ready2;

  logic [7:0] out_data,  out_data2;
  logic       out_valid, out_valid2;
  logic [2:0] level,     level2;
  logic       frame_err, frame_err2;
  logic       overflow,  overflow2;

  int n_cmp;
  int n_err;

  always #5 clk = ~clk;

  framed_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_bit(in_bit),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .frame_err(frame_err), .overflow(overflow)
  );

  // Same serial stream, MSB-first, consumer always ready.
  framed_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .FIFO_DEPTH(4)) dut_msb (
    .clk(clk), .rst(rst), .en(en), .in_bit(in_bit),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .level(level2), .frame_err(frame_err2), .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_bit = b;
    tick();
  endtask

  task automatic send_payload(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_payload(d);
    send_bit(1'b1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; en = 1'b0; in_bit = 1'b1; out_ready = 1'b0; out_ready2 = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_level", 32'(level),     32'h0);
    chk("rst_ferr",  32'(frame_err), 32'h0);
    chk("rst_ovf",   32'(overflow),  32'h0);
    rst = 1'b1;
    en  = 1'b1;
    tick(); tick(); tick();

    // 1: 0xA5 LSB-first, latency and pop
    send_payload(8'hA5);
    chk("t1_pre_valid", 32'(out_valid), 32'h0);
    send_bit(1'b1);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data",  32'(out_data),  32'hA5);
    chk("t1_level", 32'(level),     32'h1);
    chk("t1_ferr",  32'(frame_err), 32'h0);
    chk("t1_msb_data", 32'(out_data2), 32'hA5);
    out_ready = 1'b1;
    send_bit(1'b1);
    out_ready = 1'b0;
    chk("t1_pop_level", 32'(level),     32'h0);
    chk("t1_pop_valid", 32'(out_valid), 32'h0);

    // 2: bad stop bit
    send_payload(8'hA5);
    send_bit(1'b0);
    chk("t2_ferr",  32'(frame_err), 32'h1);
    chk("t2_valid", 32'(out_valid), 32'h0);
    chk("t2_level", 32'(level),     32'h0);
    chk("t2_ovf",   32'(overflow),  32'h0);
    send_bit(1'b1);
    chk("t2_ferr_clr", 32'(frame_err), 32'h0);
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    chk("t2_no_phantom", 32'(level), 32'h0);

    // 3: fill and overflow
    send_frame(8'h01);
    chk("t3_msb_data", 32'(out_data2), 32'h80);
    send_frame(8'h02);
    send_frame(8'h03);
    send_frame(8'h04);
    chk("t3_level_full", 32'(level),    32'h4);
    chk("t3_no_ovf",     32'(overflow), 32'h0);
    send_frame(8'h05);
    chk("t3_ovf",        32'(overflow),  32'h1);
    chk("t3_level_held", 32'(level),     32'h4);
    chk("t3_ferr",       32'(frame_err), 32'h0);
    tick();
    chk("t3_ovf_clr", 32'(overflow), 32'h0);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t3_drain", 32'(out_data), 32'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("t3_empty_level", 32'(level),     32'h0);
    chk("t3_empty_valid", 32'(out_valid), 32'h0);

    // 4: enable drop mid-frame, then MSB/LSB decode of 0x3C
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    en = 1'b0;
    in_bit = 1'b1;
    tick(); tick();
    en = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("t4_abort_level", 32'(level),     32'h0);
    chk("t4_abort_ferr",  32'(frame_err), 32'h0);
    chk("t4_abort_valid", 32'(out_valid), 32'h0);
    send_frame(8'h3C);
    chk("t4_data",      32'(out_data),   32'h3C);
    chk("t4_level",     32'(level),      32'h1);
    chk("t4_msb_data",  32'(out_data2),  32'h3C);
    chk("t4_msb_level", 32'(level2),     32'h1);
    chk("t4_msb_flags", 32'({frame_err2, overflow2}), 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 5: back-to-back, push on full with simultaneous pop
    send_frame(8'h00);
    send_frame(8'hFF);
    chk("t5_level2", 32'(level), 32'h2);
    send_frame(8'h11);
    send_frame(8'h22);
    chk("t5_level4", 32'(level),    32'h4);
    chk("t5_head",   32'(out_data), 32'h00);
    send_payload(8'h33);
    out_ready = 1'b1;
    send_bit(1'b1);
    out_ready = 1'b0;
    chk("t5_level_same", 32'(level),    32'h4);
    chk("t5_no_ovf",     32'(overflow), 32'h0);
    out_ready = 1'b1;
    chk("t5_d0", 32'(out_data), 32'hFF); tick();
    chk("t5_d1", 32'(out_data), 32'h11); tick();
    chk("t5_d2", 32'(out_data), 32'h22); tick();
    chk("t5_d3", 32'(out_data), 32'h33); tick();
    out_ready = 1'b0;
    chk("t5_empty", 32'(level), 32'h0);

    // 6: async reset mid-frame with words queued
    send_frame(8'h12);
    send_frame(8'h34);
    chk("t6_level_q", 32'(level), 32'h2);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b0;
    #2;
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_data",  32'(out_data),  32'h0);
    chk("t6_level", 32'(level),     32'h0);
    chk("t6_flags", 32'({frame_err, overflow}), 32'h0);
    tick();
    in_bit = 1'b1;
    rst = 1'b1;
    tick(); tick();
    send_frame(8'h5A);
    chk("t6_new_data",  32'(out_data),  32'h5A);
    chk("t6_new_level", 32'(level),     32'h1);
    chk("t6_new_valid", 32'(out_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
